// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - programmable baud tick generator with oversample, mid-bit and bit strobes
module uart_baud_gen #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 651,
    parameter int OVERSAMPLE  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             resync,
    output logic             os_tick,
    output logic             mid_tick,
    output logic             bit_tick,
    output logic             clk_out,
    output logic [DIV_W-1:0] div_q
);

    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_W-1:0] cnt;
    logic [OS_W-1:0]  os_cnt;
    logic [DIV_W-1:0] eff_div;
    logic             wrap;

    // A divisor of zero would stall the counter, so it is promoted to one.
    always_comb begin
        eff_div = (div_val == '0) ? DIV_W'(1) : div_val;
        wrap    = (cnt == div_q);
    end

    // Counters, divisor register and registered strobes; new divisor takes effect only at a period boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            os_cnt   <= '0;
            div_q    <= DIV_W'(DEFAULT_DIV);
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            clk_out  <= 1'b0;
        end else if (!en || resync) begin
            // Disabled or resynchronising: restart bit timing from the top.
            cnt      <= '0;
            os_cnt   <= '0;
            div_q    <= eff_div;
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            clk_out  <= 1'b0;
        end else if (wrap) begin
            cnt      <= '0;
            os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            div_q    <= eff_div;
            os_tick  <= 1'b1;
            mid_tick <= (os_cnt == OS_MID);
            bit_tick <= (os_cnt == OS_LAST);
            clk_out  <= 1'b0;
        end else begin
            cnt      <= cnt + 1'b1;
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            if (cnt == (div_q >> 1)) begin
                clk_out <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised baud-rate tick generator for the UART path. It replaces the fixed 100 MHz → 16×9600 divider with a runtime-programmable divisor, a configurable oversample ratio and a resync input. It produces single-cycle enable strobes for the RX oversampler (os_tick, mid_tick) and the TX shifter (bit_tick). It also keeps a 50 %-duty square output for legacy consumers.

Parameters:
DIV_W, 16, width of divisor and cycle counter
DEFAULT_DIV, 651, divisor loaded at reset (oversample period = DEFAULT_DIV+1 clk cycles; 100 MHz / 652 ≈ 16×9600)
OVERSAMPLE, 16, oversample ticks per bit; integer ≥ 4, even
OS_W, $clog2(OVERSAMPLE), oversample counter width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
en  in  1  generator enable; low holds counters and outputs at 0
div_val  in  DIV_W  requested divisor (oversample period − 1)
resync  in  1  restart bit timing (RX start-bit edge detected)
os_tick  out  1  one-cycle strobe every div_q+1 cycles
mid_tick  out  1  one-cycle strobe at oversample count OVERSAMPLE/2 (mid-bit sample)
bit_tick  out  1  one-cycle strobe every OVERSAMPLE os_ticks (bit boundary)
clk_out  out  1  square wave, period div_q+1, high for the second half
div_q  out  DIV_W  divisor currently in effect

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rst_n. All logic updates on the rising edge of clk.
- Reset: cnt=0, os_cnt=0, div_q=DEFAULT_DIV, and os_tick, mid_tick, bit_tick and clk_out all 0. Reset overrides every other input.
- Clamping: eff_div = (div_val < 1) ? 1 : div_val. Divisor 0 is never loaded.
- Divisor loading is glitch-free. div_q <= eff_div only at a wrap edge (en && cnt==div_q), or on any edge while en=0, or on resync. A mid-period change never shortens or lengthens the current period.
- Cycle counter: when en=1, cnt increments each edge. At the edge where cnt==div_q, cnt <= 0.
- Outputs are registered, so every strobe is high in the cycle after its triggering edge:
  - os_tick <= en && cnt==div_q
  - bit_tick <= en && cnt==div_q && os_cnt==OVERSAMPLE−1
  - mid_tick <= en && cnt==div_q && os_cnt==OVERSAMPLE/2−1
- os_cnt increments at each wrap edge and wraps from OVERSAMPLE−1 to 0.
- clk_out is set at the edge where cnt==(div_q>>1) and cleared at the edge where cnt==div_q.
  - If both conditions match in the same cycle, clear wins.
  - For div_q odd, high time = low time = (div_q+1)/2 cycles.
- resync (sampled high, en=1):
  - next cnt=0, os_cnt=0, clk_out=0; no strobe is generated that edge.
  - First os_tick follows div_q+1 edges later. mid_tick follows (OVERSAMPLE/2)×(div_q+1) cycles after resync; bit_tick follows OVERSAMPLE×(div_q+1) cycles after resync.
  - resync has priority over a coincident wrap.
- en=0: cnt=0, os_cnt=0, and all strobes and clk_out are driven 0 next edge. resync is ignored. On re-enable, timing restarts as after resync.
- Reset mid-operation: any cycle with rst_n=0 returns all state to reset values on that edge. No strobe is emitted until a full period after release.
- Strobes are never wider than one cycle. bit_tick and mid_tick always coincide with an os_tick.

Test Plan:
- Reset release, en=1, div_val=651 → os_tick period 652 cycles; clk_out high 326 / low 326; bit_tick every 10432 cycles; div_q=651.
- div_val=3, en=1 → os_tick every 4 cycles; mid_tick first asserted 32 cycles after enable edge, then every 64; bit_tick every 64 cycles, aligned with an os_tick.
- div_val changed 3→7 while cnt=1 → current period completes at 4 cycles, subsequent os_tick spacing 8; div_q updates to 7 on that wrap edge, not earlier.
- resync pulse at arbitrary cnt/os_cnt, div_val=3 → no strobe that edge; next os_tick 4 cycles later, mid_tick 32, bit_tick 64 cycles after resync edge.
- div_val=0 → div_q=1, os_tick every 2 cycles, clk_out alternates 1/0 each cycle.
- rst_n low for 1 cycle mid-bit, and en low for 5 cycles mid-bit → all outputs 0 the following cycle, counters 0; timing after release/re-enable identical to a fresh start.
